sram_io_responder: RTL and testbench
====================================

Name: sram_io_responder

Overview:
- Clocked behavioural responder for one external async SRAM chip (ICE40 SRAM board class). It is the memory end of the sram_io_* pins driven by the striped-arbiter memory test.
- Accepts writes with per-byte lanes and returns read data over the shared tristate bus after a programmable latency.
- Reports access counts and protocol errors (bus contention, out-of-range address, read-before-write) so benches can check controller behaviour without a vendor SRAM model.

Parameters:
- ADDR_WIDTH, 18, width of sram_io_addr.
- DATA_WIDTH, 16, width of sram_io_data. Must be a multiple of 8; the lane mask uses the two byte lanes UB/LB, and DATA_WIDTH=16 is the only supported value.
- MEM_ADDR_WIDTH, 12, number of low address bits actually backed by storage (depth = 2**MEM_ADDR_WIDTH).
- READ_LATENCY, 1, posedges between read sample and data driven; legal range 0..4.
- CNT_WIDTH, 32, width of access counters.

Ports:
- CLK, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- sram_io_addr, input, ADDR_WIDTH, word address.
- sram_io_data, inout, DATA_WIDTH, bidirectional data bus.
- sram_io_ce_n, input, 1, chip enable, active low.
- sram_io_we_n, input, 1, write enable, active low.
- sram_io_oe_n, input, 1, output enable, active low.
- sram_io_ub_n, input, 1, upper byte lane enable, active low.
- sram_io_lb_n, input, 1, lower byte lane enable, active low.
- wr_count, output, CNT_WIDTH, accepted write cycles.
- rd_count, output, CNT_WIDTH, accepted read cycles.
- err_contention, output, 1, sticky: controller wrote while the responder was driving.
- err_addr, output, 1, sticky: access with nonzero bits above MEM_ADDR_WIDTH.
- err_uninit, output, 1, sticky: a read touched a byte never written since reset.

Behaviour:
- Reset is synchronous and active-low: rst_n, clock CLK.
- While rst_n=0, at each posedge:
  - counters and error flags are cleared to 0;
  - the read pipeline is flushed;
  - the per-byte written bitmap is cleared;
  - the bus is released (Z) from the cycle after the reset edge.
- Memory contents are not reset.
- All pins are sampled at posedge CLK. Active cycle: ce_n=0. When ce_n=1 the cycle is idle, with no count and no drive request.
- Write cycle: ce_n=0 and we_n=0.
  - mem[addr] lower byte is updated if lb_n=0; upper byte if ub_n=0. The matching written bits are set.
  - wr_count increments by 1, even if both lanes are masked.
  - A write dominates oe_n: with we_n=0 and oe_n=0 the cycle is a write and nothing is driven.
- Read cycle: ce_n=0, we_n=1, oe_n=0.
  - addr and the lane mask are captured, and rd_count increments.
  - Data is read from mem at the capture edge, so a write in the same edge is not visible and a write at a later edge is not reflected.
  - If any enabled lane's written bit is 0, err_uninit is set.
- Read drive timing:
  - READ_LATENCY=0: the captured read is driven combinationally in the same cycle, from the current pins and mem.
  - READ_LATENCY=N>0: the entry moves through an N-stage valid/data/mask pipeline and is driven during the cycle after the Nth posedge following capture.
  - Reads are back-to-back capable, one per cycle.
- Drive rules:
  - Only lanes enabled in the captured mask are driven; the other lanes are Z.
  - Drive is suppressed (Z) if oe_n=1 or ce_n=1 in the drive cycle. The pipeline entry is still consumed.
- Contention: if a write cycle is sampled while the responder is driving any lane, err_contention is set and the write still commits.
- Address check: any addr bit at or above MEM_ADDR_WIDTH that is 1 sets err_addr.
  - The access is dropped: no mem update, no counter increment, no pipeline entry.
  - Because the access is dropped, the bus is Z for that read.
- Counters wrap modulo 2**CNT_WIDTH. Error flags are sticky until reset.
- Reset during a pending read: the entry is discarded and the bus is Z.

Test Plan:
- Reset, then write 0xA5C3 at addr 0x010 with both lanes, then read addr 0x010 (READ_LATENCY=1): bus reads 0xA5C3 one cycle after capture; wr_count=1, rd_count=1, all error flags 0.
- Write 0x1111 to addr 5, then write 0xFF22 with ub_n=1, then read addr 5: 0x1122.
- Read addr 7 with lb_n=0, ub_n=1 when only its low byte was written: bus upper lane Z, err_uninit=0. Then read the same address with both lanes enabled: err_uninit=1.
- 8 back-to-back reads of addrs 0..7 holding 0x0100+i, with READ_LATENCY=2: eight consecutive bus values 0x0100..0x0107 starting 2 cycles after the first capture; rd_count=8.
- Read then write on the next cycle with READ_LATENCY=1, while the responder is still driving: err_contention=1 and the write data is stored.
- Access at addr 0x1000 with MEM_ADDR_WIDTH=12: err_addr=1, counters unchanged, bus Z. Assert rst_n=0 mid-read: bus Z and counters 0 after the reset edge.

Source files
------------

// File: rtl/sram_io_responder.sv
// Behavioural clocked responder for one external async SRAM chip on the sram_io_* pins.
// Stores byte-laned writes, returns reads after READ_LATENCY edges and flags protocol errors.
module sram_io_responder #(
  parameter int ADDR_WIDTH     = 18,
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int READ_LATENCY   = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] sram_io_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_io_data,
  input  logic                  sram_io_ce_n,
  input  logic                  sram_io_we_n,
  input  logic                  sram_io_oe_n,
  input  logic                  sram_io_ub_n,
  input  logic                  sram_io_lb_n,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  err_contention,
  output logic                  err_addr,
  output logic                  err_uninit
);

  localparam int DEPTH  = 1 << MEM_ADDR_WIDTH;
  localparam int LANE   = DATA_WIDTH / 2;
  localparam int STAGES = (READ_LATENCY == 0) ? 1 : READ_LATENCY;

  logic [DATA_WIDTH-1:0]     mem     [DEPTH];
  logic [1:0]                written [DEPTH];
  logic [MEM_ADDR_WIDTH-1:0] maddr;
  logic                      addr_ok;
  logic                      wr_cyc;
  logic                      rd_cyc;
  logic                      wr_ok;
  logic                      rd_ok;
  logic [1:0]                lane_en;
  logic                      out_valid;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [1:0]                out_mask;
  logic [1:0]                drive_lane;
  logic                      driving;

  assign maddr   = sram_io_addr[MEM_ADDR_WIDTH-1:0];
  assign addr_ok = (sram_io_addr >> MEM_ADDR_WIDTH) == '0;
  assign lane_en = ~{sram_io_ub_n, sram_io_lb_n};
  assign wr_cyc  = ~sram_io_ce_n & ~sram_io_we_n;
  assign rd_cyc  = ~sram_io_ce_n & sram_io_we_n & ~sram_io_oe_n;
  assign wr_ok   = wr_cyc & addr_ok;
  assign rd_ok   = rd_cyc & addr_ok;

  // Storage itself is never reset; only the written bitmap knows what is valid.
  always_ff @(posedge CLK) begin
    if (rst_n && wr_ok) begin
      if (lane_en[0]) mem[maddr][LANE-1:0]          <= sram_io_data[LANE-1:0];
      if (lane_en[1]) mem[maddr][DATA_WIDTH-1:LANE] <= sram_io_data[DATA_WIDTH-1:LANE];
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) written[i] <= 2'b00;
    end else if (wr_ok) begin
      written[maddr] <= written[maddr] | lane_en;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      wr_count       <= '0;
      rd_count       <= '0;
      err_contention <= 1'b0;
      err_addr       <= 1'b0;
      err_uninit     <= 1'b0;
    end else begin
      if (wr_ok) wr_count <= wr_count + CNT_WIDTH'(1);
      if (rd_ok) rd_count <= rd_count + CNT_WIDTH'(1);
      if (wr_cyc && driving) err_contention <= 1'b1;
      if ((wr_cyc || rd_cyc) && !addr_ok) err_addr <= 1'b1;
      if (rd_ok && |(lane_en & ~written[maddr])) err_uninit <= 1'b1;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb
      assign out_valid = rd_ok & rst_n;
      assign out_data  = mem[maddr];
      assign out_mask  = lane_en;
    end else begin : g_pipe
      logic [STAGES-1:0]     pipe_valid;
      logic [DATA_WIDTH-1:0] pipe_data [STAGES];
      logic [1:0]            pipe_mask [STAGES];

      // Stage 0 is loaded at the capture edge, so the last stage drives after READ_LATENCY edges.
      always_ff @(posedge CLK) begin
        if (!rst_n) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= rd_ok;
          pipe_data[0]  <= mem[maddr];
          pipe_mask[0]  <= lane_en;
          for (int i = 1; i < STAGES; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_data[i]  <= pipe_data[i-1];
            pipe_mask[i]  <= pipe_mask[i-1];
          end
        end
      end

      assign out_valid = pipe_valid[STAGES-1];
      assign out_data  = pipe_data[STAGES-1];
      assign out_mask  = pipe_mask[STAGES-1];
    end
  endgenerate

  assign drive_lane = {2{out_valid & ~sram_io_oe_n & ~sram_io_ce_n}} & out_mask;
  assign driving    = |drive_lane;

  assign sram_io_data[LANE-1:0]          = drive_lane[0] ? out_data[LANE-1:0] : {LANE{1'bz}};
  assign sram_io_data[DATA_WIDTH-1:LANE] = drive_lane[1] ? out_data[DATA_WIDTH-1:LANE] : {LANE{1'bz}};

endmodule

// File: tb/tb_sram_io_responder.sv
// Bench for sram_io_responder: two instances (READ_LATENCY 1 and 2) share one stimulus stream
// and are checked every cycle against a time-indexed model of captures, storage and errors.
module tb_sram_io_responder;

  logic        CLK;
  logic        rst_n;
  logic [17:0] sram_io_addr;
  logic        sram_io_ce_n, sram_io_we_n, sram_io_oe_n, sram_io_ub_n, sram_io_lb_n;
  logic [15:0] tb_wdata;
  logic [1:0]  tb_drv;

  // Pulled-up buses make a released bus read as all ones.
  tri1 [15:0] bus1;
  tri1 [15:0] bus2;

  logic [31:0] wr_count1, rd_count1, wr_count2, rd_count2;
  logic        err_contention1, err_addr1, err_uninit1;
  logic        err_contention2, err_addr2, err_uninit2;

  int cmp_count = 0;
  int err_count = 0;

  assign tb_drv = (!sram_io_ce_n && !sram_io_we_n) ? ~{sram_io_ub_n, sram_io_lb_n} : 2'b00;
  assign bus1[7:0]  = tb_drv[0] ? tb_wdata[7:0]  : 8'bz;
  assign bus1[15:8] = tb_drv[1] ? tb_wdata[15:8] : 8'bz;
  assign bus2[7:0]  = tb_drv[0] ? tb_wdata[7:0]  : 8'bz;
  assign bus2[15:8] = tb_drv[1] ? tb_wdata[15:8] : 8'bz;

  sram_io_responder #(.READ_LATENCY(1)) dut1 (
    .CLK(CLK), .rst_n(rst_n), .sram_io_addr(sram_io_addr), .sram_io_data(bus1),
    .sram_io_ce_n(sram_io_ce_n), .sram_io_we_n(sram_io_we_n), .sram_io_oe_n(sram_io_oe_n),
    .sram_io_ub_n(sram_io_ub_n), .sram_io_lb_n(sram_io_lb_n),
    .wr_count(wr_count1), .rd_count(rd_count1), .err_contention(err_contention1),
    .err_addr(err_addr1), .err_uninit(err_uninit1)
  );

  sram_io_responder #(.READ_LATENCY(2)) dut2 (
    .CLK(CLK), .rst_n(rst_n), .sram_io_addr(sram_io_addr), .sram_io_data(bus2),
    .sram_io_ce_n(sram_io_ce_n), .sram_io_we_n(sram_io_we_n), .sram_io_oe_n(sram_io_oe_n),
    .sram_io_ub_n(sram_io_ub_n), .sram_io_lb_n(sram_io_lb_n),
    .wr_count(wr_count2), .rd_count(rd_count2), .err_contention(err_contention2),
    .err_addr(err_addr2), .err_uninit(err_uninit2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit   [1:0]  m;
    bit   [1:0]  known;
  } rec_t;

  rec_t        hist     [0:1023];
  logic [15:0] mmem     [0:4095];
  bit   [1:0]  mknown   [0:4095];
  bit   [1:0]  mwritten [0:4095];
  int          edge_n   = 0;
  int          last_rst = 0;
  bit          live     = 0;
  int unsigned mwr = 0, mrd = 0;
  bit          m_err_addr = 0, m_err_uninit = 0;
  bit          m_err_cont [2];

  // A read captured at edge c is seen on the bus in the cycle after edge c+n-1, unless a reset edge intervened.
  function automatic void exp_drive(input int n, output bit [1:0] lanes,
                                    output logic [15:0] d, output bit [1:0] known);
    int c;
    c = edge_n - n + 1;
    lanes = 2'b00; d = 16'h0; known = 2'b00;
    if (c >= 1 && c > last_rst && hist[c].v && !sram_io_ce_n && !sram_io_oe_n) begin
      lanes = hist[c].m; d = hist[c].d; known = hist[c].known;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    cmp_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkBus(input int n, input logic [15:0] bus, input string name);
    bit [1:0]    lanes, known;
    logic [15:0] d;
    exp_drive(n, lanes, d, known);
    for (int l = 0; l < 2; l++) begin
      if (!tb_drv[l]) begin
        if (lanes[l]) begin
          if (known[l]) checkOutput(name, 32'(bus[l*8 +: 8]), 32'(d[l*8 +: 8]));
        end else begin
          checkOutput(name, 32'(bus[l*8 +: 8]), 32'h0000_00FF);
        end
      end
    end
  endtask

  always @(posedge CLK) begin : model
    bit [1:0]    l1, l2, k, lanes;
    logic [15:0] d;
    int          a;
    exp_drive(1, l1, d, k);
    exp_drive(2, l2, d, k);
    edge_n++;
    hist[edge_n].v = 0;
    if (!rst_n) begin
      live = 1; last_rst = edge_n;
      mwr = 0; mrd = 0; m_err_addr = 0; m_err_uninit = 0;
      m_err_cont[0] = 0; m_err_cont[1] = 0;
      for (int i = 0; i < 4096; i++) mwritten[i] = 2'b00;
    end else begin
      lanes = ~{sram_io_ub_n, sram_io_lb_n};
      a = int'(sram_io_addr);
      if (!sram_io_ce_n && !sram_io_we_n) begin
        if (|l1) m_err_cont[0] = 1;
        if (|l2) m_err_cont[1] = 1;
        if (a >= 4096) m_err_addr = 1;
        else begin
          if (lanes[0]) mmem[a][7:0]  = tb_wdata[7:0];
          if (lanes[1]) mmem[a][15:8] = tb_wdata[15:8];
          mknown[a]   = mknown[a] | lanes;
          mwritten[a] = mwritten[a] | lanes;
          mwr++;
        end
      end else if (!sram_io_ce_n && !sram_io_oe_n) begin
        if (a >= 4096) m_err_addr = 1;
        else begin
          hist[edge_n].v = 1; hist[edge_n].d = mmem[a];
          hist[edge_n].m = lanes; hist[edge_n].known = mknown[a];
          mrd++;
          if (|(lanes & ~mwritten[a])) m_err_uninit = 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (live) begin
      checkOutput("wr_count_l1", wr_count1, mwr);
      checkOutput("rd_count_l1", rd_count1, mrd);
      checkOutput("err_addr_l1", 32'(err_addr1), 32'(m_err_addr));
      checkOutput("err_uninit_l1", 32'(err_uninit1), 32'(m_err_uninit));
      checkOutput("err_contention_l1", 32'(err_contention1), 32'(m_err_cont[0]));
      checkOutput("wr_count_l2", wr_count2, mwr);
      checkOutput("rd_count_l2", rd_count2, mrd);
      checkOutput("err_addr_l2", 32'(err_addr2), 32'(m_err_addr));
      checkOutput("err_uninit_l2", 32'(err_uninit2), 32'(m_err_uninit));
      checkOutput("err_contention_l2", 32'(err_contention2), 32'(m_err_cont[1]));
      checkBus(1, bus1, "bus_l1");
      checkBus(2, bus2, "bus_l2");
    end
  end

  task automatic applyStimulus(input bit rst, input bit ce, input bit we, input bit oe,
                               input bit ub, input bit lb, input logic [17:0] a, input logic [15:0] d);
    @(posedge CLK);
    #1;
    rst_n = rst; sram_io_ce_n = ce; sram_io_we_n = we; sram_io_oe_n = oe;
    sram_io_ub_n = ub; sram_io_lb_n = lb; sram_io_addr = a; tb_wdata = d;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input bit ub, input bit lb);
    applyStimulus(1, 0, 0, 1, ub, lb, a, d);
  endtask

  task automatic do_read(input logic [17:0] a, input bit ub, input bit lb);
    applyStimulus(1, 0, 1, 0, ub, lb, a, 16'h0);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 1, 1, 1, 1, 18'h0, 16'h0);
  endtask

  task automatic do_reset();
    applyStimulus(0, 1, 1, 1, 1, 1, 18'h0, 16'h0);
    applyStimulus(0, 1, 1, 1, 1, 1, 18'h0, 16'h0);
    do_idle(1);
  endtask

  initial begin
    rst_n = 0; sram_io_ce_n = 1; sram_io_we_n = 1; sram_io_oe_n = 1;
    sram_io_ub_n = 1; sram_io_lb_n = 1; sram_io_addr = '0; tb_wdata = '0;

    do_reset();
    @(negedge CLK);
    checkOutput("reset_wr_count", wr_count1, 32'd0);
    checkOutput("reset_flags", 32'({err_contention1, err_addr1, err_uninit1}), 32'd0);

    do_write(18'h010, 16'hA5C3, 0, 0);
    do_read(18'h010, 0, 0);
    do_read(18'h010, 0, 0);
    @(negedge CLK);
    checkOutput("rd_a5c3_bus", 32'(bus1), 32'h0000_A5C3);
    checkOutput("rd_a5c3_rd_count", rd_count1, 32'd1);
    checkOutput("rd_a5c3_wr_count", wr_count1, 32'd1);
    do_idle(2);

    do_write(18'h5, 16'h1111, 0, 0);
    do_write(18'h5, 16'hFF22, 1, 0);
    do_read(18'h5, 0, 0);
    do_read(18'h5, 0, 0);
    @(negedge CLK);
    checkOutput("lane_merge_bus", 32'(bus1), 32'h0000_1122);
    do_idle(2);

    do_write(18'h7, 16'h0034, 1, 0);
    do_read(18'h7, 1, 0);
    do_read(18'h7, 0, 0);
    @(negedge CLK);
    checkOutput("lo_only_bus", 32'(bus1), 32'h0000_FF34);
    checkOutput("lo_only_uninit", 32'(err_uninit1), 32'd0);
    do_idle(1);
    @(negedge CLK);
    checkOutput("both_lanes_uninit", 32'(err_uninit1), 32'd1);
    do_idle(2);

    do_reset();
    for (int i = 0; i < 8; i++) do_write(18'(i), 16'h0100 + 16'(i), 0, 0);
    for (int j = 0; j < 10; j++) begin
      do_read(18'(j % 8), 0, 0);
      @(negedge CLK);
      if (j >= 2) checkOutput("b2b_lat2_bus", 32'(bus2), 32'h0100 + 32'(j - 2));
      if (j == 8) checkOutput("b2b_rd_count", rd_count2, 32'd8);
    end
    do_idle(2);

    do_write(18'h20, 16'h1234, 0, 0);
    do_read(18'h20, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 18'h20, 16'hBE00);
    @(negedge CLK);
    checkOutput("contention_drive_lo", 32'(bus1[7:0]), 32'h34);
    do_idle(1);
    @(negedge CLK);
    checkOutput("contention_flag_l1", 32'(err_contention1), 32'd1);
    checkOutput("contention_flag_l2", 32'(err_contention2), 32'd0);
    do_read(18'h20, 0, 0);
    do_read(18'h20, 0, 0);
    @(negedge CLK);
    checkOutput("contention_write_stored", 32'(bus1), 32'h0000_BE34);
    do_idle(2);

    do_read(18'h1000, 0, 0);
    do_read(18'h1000, 0, 0);
    @(negedge CLK);
    checkOutput("bad_addr_flag", 32'(err_addr1), 32'd1);
    checkOutput("bad_addr_rd_count", rd_count1, 32'd13);
    checkOutput("bad_addr_bus_z", 32'(bus1), 32'h0000_FFFF);
    applyStimulus(1, 0, 0, 1, 0, 0, 18'h1000, 16'h5555);
    do_idle(1);
    @(negedge CLK);
    checkOutput("bad_addr_wr_count", wr_count1, 32'd10);
    do_read(18'h0, 0, 0);
    do_read(18'h0, 0, 0);
    @(negedge CLK);
    checkOutput("bad_addr_no_alias", 32'(bus1), 32'h0000_0100);
    do_idle(2);

    do_read(18'h010, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 18'h010, 16'h0);
    do_read(18'h010, 0, 0);
    @(negedge CLK);
    checkOutput("mid_read_reset_bus_l1", 32'(bus1), 32'h0000_FFFF);
    checkOutput("mid_read_reset_bus_l2", 32'(bus2), 32'h0000_FFFF);
    checkOutput("mid_read_reset_rd_count", rd_count1, 32'd0);
    checkOutput("mid_read_reset_err_addr", 32'(err_addr1), 32'd0);
    do_idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
